alu_operand_loader: RTL
=======================

Name: alu_operand_loader

Overview:
- Upstream stage of the 16-bit ALU datapath; the XOR, AND, OR and ADD units consume its outputs.
- Collects two operands and an opcode from a single-word input stream using a valid/ready handshake.
- Registers them and presents a stable operand pair with valid/ready to the ALU until the pair is consumed.
- Counts completed operand pairs.

Parameters:
- WIDTH, 16, operand width in bits.
- OPW, 2, opcode width in bits.
- CNTW, 8, width of the completed-pair counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  operand word from the source.
- in_op  input  OPW  opcode; sampled only on the B-operand transfer.
- in_valid  input  1  source has a word on in_data.
- in_ready  output  1  loader accepts a word this cycle.
- op_a  output  WIDTH  registered operand A to the ALU.
- op_b  output  WIDTH  registered operand B to the ALU.
- op_sel  output  OPW  registered opcode to the ALU result mux.
- out_valid  output  1  op_a/op_b/op_sel hold a complete pair.
- out_ready  input  1  ALU/result stage consumes the pair this cycle.
- result_in  input  WIDTH  ALU result; used only when ACCUM_CHAIN_EN is defined.
- pair_count  output  CNTW  number of consumed pairs, saturating.

Behaviour:
- Clock and reset: single clock clk; synchronous, active-high reset rst.
- Reset: state=LOAD_A; op_a, op_b, op_sel, pair_count = 0; out_valid = 0; in_ready = 1. Reset mid-operation discards partially loaded operands with no output.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- State LOAD_A: in_ready=1, out_valid=0. On input transfer, op_a <= in_data and go to LOAD_B.
- State LOAD_B: in_ready=1, out_valid=0. On input transfer, op_b <= in_data, op_sel <= in_op, go to HOLD.
- State HOLD: in_ready=0, out_valid=1. op_a, op_b and op_sel are frozen while out_ready=0. On output transfer, go to LOAD_A (or LOAD_B, see optional feature) and increment pair_count.
- Latency: out_valid rises the cycle after the B transfer, so there is a minimum of 2 input cycles per pair. In HOLD, a same-cycle output transfer is one cycle.
- in_ready is a registered-state decode: high in LOAD_A and LOAD_B, low in HOLD. There is no combinational path from out_ready to in_ready, so a word cannot be accepted in the cycle HOLD exits.
- in_valid is ignored in HOLD; the source must hold its word.
- pair_count saturates at 2^CNTW-1 and does not wrap.
- in_op in LOAD_A is don't-care.
- Output registers change only on the transfers listed above.
- Unused state encoding goes to LOAD_A.

Optional Feature:
- Macro: ACCUM_CHAIN_EN.
- Defined: on output transfer in HOLD, op_a <= result_in and the FSM goes to LOAD_B. Each pair after the first then needs one input word, enabling chained operations (e.g. repeated XOR).
- Not defined: result_in is ignored; HOLD always returns to LOAD_A.
- rst always returns the FSM to LOAD_A in both builds.

Decomposition:
- Package alu_pkg:
  - OP_ADD=2'd0, OP_AND=2'd1, OP_OR=2'd2, OP_XOR=2'd3.
  - State typedef loader_state_t {LOAD_A, LOAD_B, HOLD}.
  - Default WIDTH constant 16.
- One sub-module, sat_counter (CNTW-wide, synchronous clear, increment enable, saturation), instantiated for pair_count. FSM and operand registers stay in the top module.

Test Plan:
- Reset then words 16'h00FF (A), 16'h0F0F with op=OP_XOR (B), out_ready=1 -> out_valid=1 one cycle after B; op_a=00FF, op_b=0F0F, op_sel=3; pair_count=1 after the transfer.
- Backpressure: out_ready=0 for 5 cycles in HOLD while in_valid=1 with 16'hDEAD -> in_ready=0, outputs unchanged, no word consumed. Then out_ready=1 -> state LOAD_A and 16'hDEAD accepted as A on the next cycle.
- Reset mid-operation: assert rst after A=16'h1234 loaded -> state LOAD_A, op_a=0, out_valid=0, and the next two words form the new pair.
- Saturation with CNTW=2: 5 consecutive pairs -> pair_count reads 1,2,3,3,3.
- ACCUM_CHAIN_EN build: A=16'h0001, B=16'h0003 op XOR, result_in=16'h0002 at transfer -> next pair needs one word 16'h0007; op_a=0002, op_b=0007. Without the macro, the same stimulus takes 16'h0007 as A.

Source files
------------

// File: rtl/alu_operand_loader_pkg.sv
// Shared opcode, state and width definitions for the ALU operand loader.
package alu_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int OPW_DEFAULT   = 2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } loader_state_t;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Input word stream and registered operand-pair stream of the ALU operand loader.
interface alu_operand_loader_if
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int OPW   = OPW_DEFAULT
);

  logic [WIDTH-1:0] in_data;
  logic [OPW-1:0]   in_op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [OPW-1:0]   op_sel;
  logic             out_valid;
  logic             out_ready;

  // Master is the source/ALU side, slave is the loader.
  modport master (
    output in_data, in_op, in_valid, out_ready,
    input  in_ready, op_a, op_b, op_sel, out_valid
  );

  modport slave (
    input  in_data, in_op, in_valid, out_ready,
    output in_ready, op_a, op_b, op_sel, out_valid
  );

endinterface

// File: rtl/alu_operand_loader_sat_counter.sv
// Saturating up-counter with synchronous reset/clear and increment enable.
module sat_counter
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/alu_operand_loader.sv
// Collects operand A, operand B and opcode from a word stream and holds the pair for the ALU.
// Optional macro ACCUM_CHAIN_EN: a consumed pair feeds result_in back as the next operand A.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int OPW   = OPW_DEFAULT,
  parameter int CNTW  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_operand_loader_if.slave   bus,
  input  logic [WIDTH-1:0]      result_in,
  output logic [CNTW-1:0]       pair_count
);

`ifdef ACCUM_CHAIN_EN
  localparam loader_state_t HOLD_EXIT = LOAD_B;
`else
  localparam loader_state_t HOLD_EXIT = LOAD_A;
  logic unused_result;
  assign unused_result = ^result_in;
`endif

  loader_state_t    state;
  loader_state_t    next_state;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_A;
    end else begin
      state <= next_state;
    end
  end

  // Handshake outputs decode only the state register, so out_ready never reaches in_ready.
  always_comb begin
    next_state    = LOAD_A;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      LOAD_A: begin
        bus.in_ready = 1'b1;
        next_state   = bus.in_valid ? LOAD_B : LOAD_A;
      end
      LOAD_B: begin
        bus.in_ready = 1'b1;
        next_state   = bus.in_valid ? HOLD : LOAD_B;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        next_state    = bus.out_ready ? HOLD_EXIT : HOLD;
      end
      default: begin
        next_state = LOAD_A;
      end
    endcase
  end

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sel_q <= '0;
    end else begin
      if (in_fire && (state == LOAD_A)) begin
        a_q <= bus.in_data;
      end
      if (in_fire && (state == LOAD_B)) begin
        b_q   <= bus.in_data;
        sel_q <= bus.in_op;
      end
`ifdef ACCUM_CHAIN_EN
      if (out_fire) begin
        a_q <= result_in;
      end
`endif
    end
  end

  assign bus.op_a   = a_q;
  assign bus.op_b   = b_q;
  assign bus.op_sel = sel_q;

  sat_counter #(.W(CNTW)) u_pair_count (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .inc   (out_fire),
    .count (pair_count)
  );

endmodule
